// File: rtl/dma_arb_pkg.sv
// dma_arb_pkg
// Shared definitions for the DMA request arbiter:
//   - dma_arb_state_e : arbiter FSM state encoding (exported on the debug port)
//   - CONF_*          : bit positions inside the config_o register image
//   - ST_*            : bit positions inside the state_i DMA status word
package dma_arb_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ARB   = 3'd1,
      S_LOAD  = 3'd2,
      S_START = 3'd3,
      S_BUSY  = 3'd4,
      S_CLEAR = 3'd5,
      S_DRAIN = 3'd6
   } dma_arb_state_e;

   // config_o bit positions
   localparam int CONF_START    = 0;
   localparam int CONF_CLR_DONE = 1;

   // state_i bit positions
   localparam int ST_BUSY = 0;
   localparam int ST_DONE = 1;

endpackage

// File: rtl/dma_rr_arbiter.sv
// dma_rr_arbiter
// Purely combinational round-robin selector. The search starts at the index
// just after ptr_i and wraps from NUM_REQ-1 back to 0, so the requester that
// was granted last has the lowest priority.
// Ports:
//   req_i   : request vector
//   ptr_i   : index of the last granted requester
//   gnt_o   : one-hot grant (all zero when nothing is requested)
//   idx_o   : binary index of the granted requester
//   valid_o : at least one request present
module dma_rr_arbiter #(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         req_i,
   input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
   output logic [NUM_REQ-1:0]         gnt_o,
   output logic [$clog2(NUM_REQ)-1:0] idx_o,
   output logic                       valid_o
);

   localparam int IDX_W = $clog2(NUM_REQ);

   int cand;

   always_comb begin
      gnt_o   = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      cand    = 0;
      for (int off = 1; off <= NUM_REQ; off++) begin
         cand = (int'(ptr_i) + off) % NUM_REQ;
         if (!valid_o && req_i[cand]) begin
            valid_o     = 1'b1;
            gnt_o[cand] = 1'b1;
            idx_o       = IDX_W'(cand);
         end
      end
   end

endmodule

// File: rtl/dma_req_arbiter.sv
// dma_req_arbiter
// Shares one DMA engine between NUM_REQ requesters. A requester is picked
// round-robin, its length/source/destination are copied into the DMA register
// image, the engine is started, and completion is acknowledged with a
// clear-done pulse before the next requester is considered.
//
// Ports:
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   req_i                : per-requester request level, held until gnt_o
//   len_i, src_i, dst_i  : packed per-requester transfer fields
//   gnt_o                : one-cycle pulse, request accepted
//   done_o               : one-cycle pulse, granted transfer completed
//   err_o                : one-cycle pulse, request rejected (or timed out)
//   config_o             : DMA control word (bit0 start, bit1 clear-done)
//   length_o, source_addr_o, dest_addr_o : DMA register image
//   state_i              : DMA status (bit0 busy, bit1 done)
//   fsm_state_o          : current FSM state, for debug/observability
//
// Optional build macro DMA_ARB_TIMEOUT_EN: adds a watchdog over START/BUSY.
// After TIMEOUT_CYCLES cycles without completion the transfer is aborted with
// err_o and a clear-done pulse. Without the macro START/BUSY wait forever.
//
// Handshake: req_i is a level that the requester must hold until it observes
// gnt_o; gnt_o, done_o and err_o are single-cycle pulses, at most one bit set.
module dma_req_arbiter
   import dma_arb_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int DATA_WIDTH     = 32,
   parameter int MAX_LEN        = 255,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic [NUM_REQ-1:0]            req_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] len_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] src_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] dst_i,
   output logic [NUM_REQ-1:0]            gnt_o,
   output logic [NUM_REQ-1:0]            done_o,
   output logic [NUM_REQ-1:0]            err_o,
   output logic [DATA_WIDTH-1:0]         config_o,
   output logic [DATA_WIDTH-1:0]         length_o,
   output logic [DATA_WIDTH-1:0]         source_addr_o,
   output logic [DATA_WIDTH-1:0]         dest_addr_o,
   input  logic [DATA_WIDTH-1:0]         state_i,
   output dma_arb_state_e                fsm_state_o
);

   localparam int IDX_W = $clog2(NUM_REQ);

   if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
      $error("dma_req_arbiter: NUM_REQ must be in 2..8");
   end
   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("dma_req_arbiter: TIMEOUT_CYCLES must be at least 2");
   end

   dma_arb_state_e      state_q;
   logic [IDX_W-1:0]    rr_ptr_q;
   logic [NUM_REQ-1:0]  owner_q;     // one-hot id of the requester being served
   logic [NUM_REQ-1:0]  err_pend_q;  // delays the illegal-length err_o by a cycle

   logic [NUM_REQ-1:0]  rr_gnt;
   logic [IDX_W-1:0]    rr_idx;
   logic                rr_valid;

   logic [DATA_WIDTH-1:0] len_sel;
   logic [DATA_WIDTH-1:0] src_sel;
   logic [DATA_WIDTH-1:0] dst_sel;
   logic                  len_ok;
   logic                  dma_busy;
   logic                  dma_done;
   logic                  unused_state_bits;

   assign fsm_state_o = state_q;

   dma_rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rr (
      .req_i   (req_i),
      .ptr_i   (rr_ptr_q),
      .gnt_o   (rr_gnt),
      .idx_o   (rr_idx),
      .valid_o (rr_valid)
   );

   assign len_sel = len_i[int'(rr_idx)*DATA_WIDTH +: DATA_WIDTH];
   assign src_sel = src_i[int'(rr_idx)*DATA_WIDTH +: DATA_WIDTH];
   assign dst_sel = dst_i[int'(rr_idx)*DATA_WIDTH +: DATA_WIDTH];
   assign len_ok  = (len_sel != '0) && (len_sel <= DATA_WIDTH'(MAX_LEN));

   assign dma_busy = state_i[ST_BUSY];
   assign dma_done = state_i[ST_DONE];
   // Only the two low status bits carry meaning.
   assign unused_state_bits = ^(state_i >> 2);

`ifdef DMA_ARB_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
   logic [TMO_W-1:0] tmo_cnt_q;
   logic             tmo_hit;
   // Counter is 0 in the first START cycle, so the hit lands on the
   // TIMEOUT_CYCLES-th cycle spent in START/BUSY.
   assign tmo_hit = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= S_IDLE;
         rr_ptr_q      <= IDX_W'(NUM_REQ - 1);
         owner_q       <= '0;
         err_pend_q    <= '0;
         gnt_o         <= '0;
         done_o        <= '0;
         err_o         <= '0;
         config_o      <= '0;
         length_o      <= '0;
         source_addr_o <= '0;
         dest_addr_o   <= '0;
`ifdef DMA_ARB_TIMEOUT_EN
         tmo_cnt_q     <= '0;
`endif
      end else begin
         gnt_o      <= '0;
         done_o     <= '0;
         err_o      <= err_pend_q;
         err_pend_q <= '0;

         case (state_q)
            S_IDLE: begin
               // While a grant pulse is still visible the requester has not
               // yet had a chance to drop its request; ignore it this cycle.
               if ((|req_i) && (gnt_o == '0)) begin
                  state_q <= S_ARB;
               end
            end

            S_ARB: begin
               if (rr_valid) begin
                  gnt_o    <= rr_gnt;
                  owner_q  <= rr_gnt;
                  rr_ptr_q <= rr_idx;
                  if (len_ok) begin
                     length_o      <= len_sel;
                     source_addr_o <= src_sel;
                     dest_addr_o   <= dst_sel;
                     config_o      <= '0;
                     state_q       <= S_LOAD;
                  end else begin
                     err_pend_q <= rr_gnt;
                     state_q    <= S_IDLE;
                  end
               end else begin
                  state_q <= S_IDLE;
               end
            end

            S_LOAD: begin
               config_o             <= '0;
               config_o[CONF_START] <= 1'b1;
               state_q              <= S_START;
`ifdef DMA_ARB_TIMEOUT_EN
               tmo_cnt_q            <= '0;
`endif
            end

            S_START: begin
               if (dma_busy || dma_done) begin
                  config_o[CONF_START] <= 1'b0;
                  state_q              <= S_BUSY;
               end
`ifdef DMA_ARB_TIMEOUT_EN
               tmo_cnt_q <= tmo_cnt_q + 1'b1;
`endif
            end

            S_BUSY: begin
               if (dma_done) begin
                  config_o                <= '0;
                  config_o[CONF_CLR_DONE] <= 1'b1;
                  done_o                  <= owner_q;
                  state_q                 <= S_CLEAR;
               end
`ifdef DMA_ARB_TIMEOUT_EN
               tmo_cnt_q <= tmo_cnt_q + 1'b1;
`endif
            end

            S_CLEAR: begin
               config_o <= '0;
               state_q  <= S_DRAIN;
            end

            S_DRAIN: begin
               if (!dma_done) begin
                  state_q <= S_IDLE;
               end
            end

            default: state_q <= S_IDLE;
         endcase

`ifdef DMA_ARB_TIMEOUT_EN
         // Watchdog overrides the normal START/BUSY progress: abort with
         // err_o instead of done_o, but still issue the clear-done pulse.
         if ((state_q == S_START || state_q == S_BUSY) && tmo_hit) begin
            config_o                <= '0;
            config_o[CONF_CLR_DONE] <= 1'b1;
            done_o                  <= '0;
            err_o                   <= owner_q;
            state_q                 <= S_CLEAR;
         end
`endif
      end
   end

endmodule

// File: tb/tb_dma_req_arbiter.sv
module tb_dma_req_arbiter;
   import dma_arb_pkg::*;

   localparam int NR  = 4;
   localparam int DW  = 32;
   localparam int TMO = 64;

   // ---------------- clock / reset ----------------
   logic                 clk_i = 1'b0;
   logic                 rst_ni;
   logic [NR-1:0]        req_i;
   logic [NR*DW-1:0]     len_i;
   logic [NR*DW-1:0]     src_i;
   logic [NR*DW-1:0]     dst_i;
   logic [NR-1:0]        gnt_o;
   logic [NR-1:0]        done_o;
   logic [NR-1:0]        err_o;
   logic [DW-1:0]        config_o;
   logic [DW-1:0]        length_o;
   logic [DW-1:0]        source_addr_o;
   logic [DW-1:0]        dest_addr_o;
   logic [DW-1:0]        state_i;
   dma_arb_state_e       fsm_state_o;

   always #5 clk_i = ~clk_i;

   dma_req_arbiter #(
      .NUM_REQ        (NR),
      .DATA_WIDTH     (DW),
      .MAX_LEN        (255),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .req_i         (req_i),
      .len_i         (len_i),
      .src_i         (src_i),
      .dst_i         (dst_i),
      .gnt_o         (gnt_o),
      .done_o        (done_o),
      .err_o         (err_o),
      .config_o      (config_o),
      .length_o      (length_o),
      .source_addr_o (source_addr_o),
      .dest_addr_o   (dest_addr_o),
      .state_i       (state_i),
      .fsm_state_o   (fsm_state_o)
   );

   // ---------------- DMA engine model ----------------
   int done_delay = 20;
   bit never_done = 1'b0;
   int busy_cnt;

   always @(posedge clk_i) begin
      #1;
      if (!rst_ni) begin
         state_i  = '0;
         busy_cnt = 0;
      end else if (config_o[CONF_CLR_DONE]) begin
         state_i = '0;
      end else if (config_o[CONF_START] && state_i == '0) begin
         state_i  = 32'h1;
         busy_cnt = 0;
      end else if (state_i[ST_BUSY]) begin
         busy_cnt++;
         if (!never_done && busy_cnt >= done_delay) state_i = 32'h2;
      end
   end

   // ---------------- scoreboard / monitor ----------------
   logic [1:0] exp_q[$];
   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int done_cnt[NR];
   int err_cnt[NR];
   int cfg_nonzero   = 0;
   int onehot_viol   = 0;
   int last_done_cyc = 0;

   always @(negedge clk_i) begin
      cyc++;
      if (rst_ni) begin
         if ($countones(gnt_o) > 1 || $countones(done_o) > 1 || $countones(err_o) > 1)
            onehot_viol++;
         for (int i = 0; i < NR; i++) begin
            if (done_o[i]) done_cnt[i]++;
            if (err_o[i])  err_cnt[i]++;
         end
         if (config_o != '0) cfg_nonzero++;
         if (done_o != '0) last_done_cyc = cyc;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(negedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      rst_ni     = 1'b0;
      req_i      = '0;
      len_i      = '0;
      src_i      = '0;
      dst_i      = '0;
      never_done = 1'b0;
      repeat (3) tick();
      rst_ni = 1'b1;
      tick();
   endtask

   task automatic set_fields(input int idx, input logic [DW-1:0] len,
                             input logic [DW-1:0] src, input logic [DW-1:0] dst);
      len_i[idx*DW +: DW] = len;
      src_i[idx*DW +: DW] = src;
      dst_i[idx*DW +: DW] = dst;
   endtask

   task automatic wait_gnt(input int max, output int idx, output bit ok);
      ok  = 1'b0;
      idx = -1;
      for (int i = 0; i < max; i++) begin
         tick();
         if (gnt_o != '0) begin
            ok = 1'b1;
            for (int k = 0; k < NR; k++) if (gnt_o[k]) idx = k;
            break;
         end
      end
   endtask

   task automatic wait_state(input dma_arb_state_e st, input int max, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         tick();
         if (fsm_state_o == st) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_ni = 1'b0;
      req_i  = '0;
      len_i  = '0;
      src_i  = '0;
      dst_i  = '0;
      tick();
      tick();
      n_checks++;
      if ({gnt_o, done_o, err_o} !== '0)
         $display("FAIL reset_pulses: got %h expected 0", {gnt_o, done_o, err_o});
      else n_pass++;
      n_checks++;
      if ({config_o, length_o, source_addr_o, dest_addr_o} !== '0)
         $display("FAIL reset_image: got %h/%h/%h/%h expected all 0",
                  config_o, length_o, source_addr_o, dest_addr_o);
      else n_pass++;
      n_checks++;
      if (fsm_state_o !== S_IDLE)
         $display("FAIL reset_state: got %0d expected %0d", fsm_state_o, S_IDLE);
      else n_pass++;
      rst_ni = 1'b1;
      repeat (3) tick();
      n_checks++;
      if (fsm_state_o !== S_IDLE || gnt_o !== '0)
         $display("FAIL idle_no_req: state %0d gnt %b expected IDLE/0000", fsm_state_o, gnt_o);
      else n_pass++;
   endtask

   task automatic test_single();
      int  idx;
      bit  ok;
      do_reset();
      done_delay = 20;
      set_fields(0, 32'd16, 32'h1000, 32'h2000);
      req_i = 4'b0001;
      wait_gnt(10, idx, ok);
      req_i = '0;
      n_checks++;
      if (!ok || gnt_o !== 4'b0001)
         $display("FAIL single_gnt: got %b (seen %0d) expected 0001", gnt_o, ok);
      else n_pass++;
      n_checks++;
      if (length_o !== 32'd16 || source_addr_o !== 32'h1000 || dest_addr_o !== 32'h2000)
         $display("FAIL single_image: got %0d/%h/%h expected 16/1000/2000",
                  length_o, source_addr_o, dest_addr_o);
      else n_pass++;
      n_checks++;
      if (config_o !== 32'd0)
         $display("FAIL single_load_cfg: got %h expected 0", config_o);
      else n_pass++;
      tick();
      n_checks++;
      if (config_o !== 32'd1)
         $display("FAIL single_start_cfg: got %h expected 1", config_o);
      else n_pass++;
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (config_o == 32'd2) begin
            ok = 1'b1;
            break;
         end
      end
      n_checks++;
      if (!ok || done_o !== 4'b0001)
         $display("FAIL single_clear: cfg2 seen %0d done %b expected 1/0001", ok, done_o);
      else n_pass++;
      n_checks++;
      if (length_o !== 32'd16 || source_addr_o !== 32'h1000 || dest_addr_o !== 32'h2000)
         $display("FAIL single_stable: got %0d/%h/%h expected 16/1000/2000",
                  length_o, source_addr_o, dest_addr_o);
      else n_pass++;
      tick();
      n_checks++;
      if (config_o !== 32'd0 || done_o !== '0)
         $display("FAIL single_pulse_len: cfg %h done %b expected 0/0000", config_o, done_o);
      else n_pass++;
      wait_state(S_IDLE, 10, ok);
      n_checks++;
      if (!ok) $display("FAIL single_idle: state %0d expected IDLE", fsm_state_o);
      else n_pass++;
   endtask

   task automatic test_round_robin();
      int                idx;
      bit                ok;
      int                base_done[NR];
      int                exp_done[NR];
      logic [DW-1:0]     src_tab[NR];
      logic [1:0]        exp_idx;
      do_reset();
      done_delay = 3;
      for (int i = 0; i < NR; i++) begin
         src_tab[i] = 32'h1000 + 32'h100 * i;
         set_fields(i, 32'd8 + i, src_tab[i], 32'h8000 + 32'h100 * i);
         base_done[i] = done_cnt[i];
      end
      exp_done[0] = 2; exp_done[1] = 1; exp_done[2] = 1; exp_done[3] = 1;
      exp_q.push_back(2'd0);
      exp_q.push_back(2'd1);
      exp_q.push_back(2'd2);
      exp_q.push_back(2'd3);
      exp_q.push_back(2'd0);
      req_i = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         wait_gnt(100, idx, ok);
         if (g == 4) req_i = '0;
         exp_idx = exp_q.pop_front();
         n_checks++;
         if (!ok || idx != int'(exp_idx))
            $display("FAIL rr_order[%0d]: got %0d expected %0d", g, idx, exp_idx);
         else n_pass++;
         n_checks++;
         if (source_addr_o !== src_tab[exp_idx])
            $display("FAIL rr_src[%0d]: got %h expected %h", g, source_addr_o, src_tab[exp_idx]);
         else n_pass++;
      end
      wait_state(S_IDLE, 100, ok);
      for (int i = 0; i < NR; i++) begin
         n_checks++;
         if (!ok || done_cnt[i] - base_done[i] != exp_done[i])
            $display("FAIL rr_done[%0d]: got %0d expected %0d", i, done_cnt[i] - base_done[i], exp_done[i]);
         else n_pass++;
      end
   endtask

   task automatic test_illegal_len();
      int idx;
      bit ok;
      int base_cfg;
      int base_err;
      int base_done;
      do_reset();
      done_delay = 4;
      base_cfg  = cfg_nonzero;
      base_err  = err_cnt[0];
      base_done = done_cnt[0];
      set_fields(0, 32'd0, 32'h10, 32'h20);
      req_i = 4'b0001;
      wait_gnt(10, idx, ok);
      req_i = '0;
      n_checks++;
      if (!ok || gnt_o !== 4'b0001)
         $display("FAIL len0_gnt: got %b expected 0001", gnt_o);
      else n_pass++;
      tick();
      n_checks++;
      if (err_o !== 4'b0001)
         $display("FAIL len0_err: got %b expected 0001", err_o);
      else n_pass++;
      tick();
      n_checks++;
      if (err_o !== '0)
         $display("FAIL len0_err_pulse: got %b expected 0000", err_o);
      else n_pass++;
      set_fields(0, 32'd256, 32'h10, 32'h20);
      req_i = 4'b0001;
      wait_gnt(10, idx, ok);
      req_i = '0;
      tick();
      n_checks++;
      if (!ok || err_o !== 4'b0001)
         $display("FAIL len256_err: got %b (gnt seen %0d) expected 0001", err_o, ok);
      else n_pass++;
      tick();
      n_checks++;
      if (cfg_nonzero != base_cfg || fsm_state_o !== S_IDLE)
         $display("FAIL illegal_cfg: cfg busy cycles %0d state %0d expected 0/IDLE",
                  cfg_nonzero - base_cfg, fsm_state_o);
      else n_pass++;
      set_fields(0, 32'd255, 32'h30, 32'h40);
      req_i = 4'b0001;
      wait_gnt(10, idx, ok);
      req_i = '0;
      n_checks++;
      if (!ok || length_o !== 32'd255)
         $display("FAIL len255_image: got %0d expected 255", length_o);
      else n_pass++;
      wait_state(S_IDLE, 100, ok);
      n_checks++;
      if (!ok || done_cnt[0] - base_done != 1 || err_cnt[0] - base_err != 2)
         $display("FAIL len255_result: done %0d err %0d expected 1/2",
                  done_cnt[0] - base_done, err_cnt[0] - base_err);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      int idx;
      bit ok;
      int base_done;
      int base_err;
      do_reset();
      done_delay = 20;
      set_fields(2, 32'd32, 32'h3000, 32'h4000);
      req_i = 4'b0100;
      wait_gnt(10, idx, ok);
      req_i = '0;
      n_checks++;
      if (!ok || idx != 2) $display("FAIL mid_first_gnt: got %0d expected 2", idx);
      else n_pass++;
      wait_state(S_BUSY, 20, ok);
      repeat (3) tick();
      base_done = done_cnt[0] + done_cnt[1] + done_cnt[2] + done_cnt[3];
      base_err  = err_cnt[0] + err_cnt[1] + err_cnt[2] + err_cnt[3];
      rst_ni = 1'b0;
      #1;
      n_checks++;
      if (!ok || {gnt_o, done_o, err_o, config_o, length_o, source_addr_o, dest_addr_o} !== '0
          || fsm_state_o !== S_IDLE)
         $display("FAIL mid_reset_outs: busy seen %0d cfg %h len %h state %0d expected all 0/IDLE",
                  ok, config_o, length_o, fsm_state_o);
      else n_pass++;
      repeat (2) tick();
      rst_ni = 1'b1;
      for (int i = 0; i < NR; i++) set_fields(i, 32'd5, 32'h5000 + i, 32'h6000 + i);
      req_i = 4'b1111;
      wait_gnt(10, idx, ok);
      req_i = '0;
      n_checks++;
      if (!ok || idx != 0) $display("FAIL mid_next_gnt: got %0d expected 0", idx);
      else n_pass++;
      wait_state(S_IDLE, 100, ok);
      n_checks++;
      if (!ok || (done_cnt[0] + done_cnt[1] + done_cnt[2] + done_cnt[3]) - base_done != 1
          || (err_cnt[0] + err_cnt[1] + err_cnt[2] + err_cnt[3]) != base_err)
         $display("FAIL mid_pulses: done delta %0d err delta %0d expected 1/0",
                  (done_cnt[0] + done_cnt[1] + done_cnt[2] + done_cnt[3]) - base_done,
                  (err_cnt[0] + err_cnt[1] + err_cnt[2] + err_cnt[3]) - base_err);
      else n_pass++;
   endtask

   task automatic test_hold_off();
      int idx;
      bit ok;
      int base_done1;
      do_reset();
      done_delay = 6;
      set_fields(1, 32'd10, 32'h1100, 32'h2100);
      set_fields(2, 32'd20, 32'h1200, 32'h2200);
      base_done1 = done_cnt[1];
      req_i = 4'b0010;
      wait_gnt(10, idx, ok);
      req_i = '0;
      n_checks++;
      if (!ok || idx != 1) $display("FAIL hold_first_gnt: got %0d expected 1", idx);
      else n_pass++;
      wait_state(S_BUSY, 20, ok);
      req_i = 4'b0100;
      wait_gnt(100, idx, ok);
      req_i = '0;
      n_checks++;
      if (!ok || idx != 2) $display("FAIL hold_second_gnt: got %0d expected 2", idx);
      else n_pass++;
      n_checks++;
      if (done_cnt[1] - base_done1 != 1 || cyc - last_done_cyc != 4)
         $display("FAIL hold_gap: done1 %0d gap %0d expected 1/4",
                  done_cnt[1] - base_done1, cyc - last_done_cyc);
      else n_pass++;
      wait_state(S_IDLE, 100, ok);
   endtask

   task automatic test_timeout();
      int idx;
      bit ok;
      int base_err;
      int base_done;
      do_reset();
      never_done = 1'b1;
      base_err  = err_cnt[0];
      base_done = done_cnt[0];
      set_fields(0, 32'd16, 32'h7000, 32'h7800);
      req_i = 4'b0001;
      wait_gnt(10, idx, ok);
      req_i = '0;
      tick();
`ifdef DMA_ARB_TIMEOUT_EN
      begin
         int start_cyc;
         start_cyc = cyc;
         ok = 1'b0;
         for (int i = 0; i < 200; i++) begin
            tick();
            if (err_o != '0) begin
               ok = 1'b1;
               break;
            end
         end
         n_checks++;
         if (!ok || err_o !== 4'b0001 || cyc - start_cyc != TMO)
            $display("FAIL tmo_err: err %b after %0d cycles expected 0001 after %0d",
                     err_o, cyc - start_cyc, TMO);
         else n_pass++;
         n_checks++;
         if (config_o !== 32'd2 || done_cnt[0] != base_done)
            $display("FAIL tmo_clear: cfg %h done delta %0d expected 2/0",
                     config_o, done_cnt[0] - base_done);
         else n_pass++;
         wait_state(S_IDLE, 10, ok);
         n_checks++;
         if (!ok) $display("FAIL tmo_idle: state %0d expected IDLE", fsm_state_o);
         else n_pass++;
      end
`else
      repeat (200) tick();
      n_checks++;
      if (fsm_state_o !== S_BUSY || err_cnt[0] != base_err || done_cnt[0] != base_done)
         $display("FAIL no_tmo_wait: state %0d err delta %0d done delta %0d expected BUSY/0/0",
                  fsm_state_o, err_cnt[0] - base_err, done_cnt[0] - base_done);
      else n_pass++;
`endif
      do_reset();
   endtask

   task automatic test_onehot();
      n_checks++;
      if (onehot_viol != 0)
         $display("FAIL onehot_pulses: got %0d multi-bit cycles expected 0", onehot_viol);
      else n_pass++;
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      for (int i = 0; i < NR; i++) begin
         done_cnt[i] = 0;
         err_cnt[i]  = 0;
      end
      test_reset();
      test_single();
      test_round_robin();
      test_illegal_len();
      test_reset_mid();
      test_hold_off();
      test_timeout();
      test_onehot();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
